hamming_enc_stream: RTL and testbench

// - Streaming Hamming(N, IP_BIT) single-error-correcting encoder, N = IP_BIT+4; transmit-side partner of the HAMMING_IP decoder.
// - Accepts data words over a valid/ready handshake and emits codewords in a 2-stage pipeline that stalls under backpressure.
// - Optional per-word single-bit error injection, so benches can drive the decoder with correctable errors.
// - Keeps running counters of words emitted and words corrupted.

---
 rtl/hamming_enc_stream.sv | 159 +++++++++++++++
 tb/tb_hamming_enc_stream.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hamming_enc_stream.sv
// Streaming Hamming(IP_BIT+4, IP_BIT) SEC encoder.
// Two-stage valid/ready pipeline: stage 1 captures {data, inject_pos}, stage 2
// holds the encoded (and optionally corrupted) codeword until the sink takes it.
// Parity bits live at positions 1,2,4,8. Data fills the remaining positions in
// ascending order, MSB first. Position p maps to out_code[N-p].
module hamming_enc_stream #(
  parameter int IP_BIT = 11,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IP_BIT-1:0] in_data,
  input  logic [3:0]        inject_pos,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IP_BIT+3:0] out_code,
  output logic              out_inj,
  output logic [CNT_W-1:0]  word_cnt,
  output logic [CNT_W-1:0]  err_cnt
);

  localparam int N = IP_BIT + 4;

  // Place data bits at non-power-of-two positions. Each set data bit folds its
  // position index into the syndrome. Parity bit 2^k takes syndrome bit k, so
  // the XOR of all set positions of a clean codeword comes out as zero.
  function automatic logic [N-1:0] encode(input logic [IP_BIT-1:0] d);
    logic [N-1:0] c;
    logic [3:0]   syn;
    int           di;
    c   = '0;
    syn = '0;
    di  = IP_BIT - 1;
    for (int p = 1; p <= N; p++) begin
      if ((p & (p - 1)) != 0) begin
        c[N-p] = d[di];
        if (d[di]) syn = syn ^ 4'(p);
        di = di - 1;
      end
    end
    c[N-1] = syn[0];
    c[N-2] = syn[1];
    c[N-4] = syn[2];
    c[N-8] = syn[3];
    return c;
  endfunction

  // Stage 1 state
  logic              s1_valid_q, s1_valid_d;
  logic [IP_BIT-1:0] s1_data_q,  s1_data_d;
  logic [3:0]        s1_inj_q,   s1_inj_d;

  // Stage 2 (output) state
  logic              out_valid_q, out_valid_d;
  logic [N-1:0]      out_code_q,  out_code_d;
  logic              out_inj_q,   out_inj_d;

  // Hand-off counters
  logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
  logic [CNT_W-1:0]  err_cnt_q,  err_cnt_d;

  // Datapath and handshake intermediates
  logic              s2_load;
  logic              in_xfer;
  logic              out_xfer;
  logic [N-1:0]      flip_mask;
  logic [N-1:0]      enc_code;

  // Handshake: stage 2 refills whenever it is empty or being drained this cycle.
  // Stage 1 accepts when empty or when it is moving its word forward.
  always_comb begin
    s2_load  = s1_valid_q && (!out_valid_q || out_ready);
    in_ready = !s1_valid_q || s2_load;
    in_xfer  = in_valid && in_ready;
    out_xfer = out_valid_q && out_ready;
  end

  // Encode the stage-1 word and build the one-hot flip for legal inject positions.
  // Positions 0 and anything above N produce an empty mask, which means no flip.
  always_comb begin
    flip_mask = '0;
    for (int p = 1; p <= N; p++) begin
      if (s1_inj_q == 4'(p)) flip_mask[N-p] = 1'b1;
    end
    enc_code = encode(s1_data_q) ^ flip_mask;
  end

  // Stage 1 next state: capture on input transfer, empty when forwarded alone.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_inj_d   = s1_inj_q;
    if (in_xfer) begin
      s1_valid_d = 1'b1;
      s1_data_d  = in_data;
      s1_inj_d   = inject_pos;
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end
  end

  // Stage 2 next state: a load replaces the current word without a bubble, and
  // out_valid drops only on a transfer with nothing arriving behind it. While
  // stalled, out_code and out_inj stay untouched.
  always_comb begin
    out_valid_d = out_valid_q;
    out_code_d  = out_code_q;
    out_inj_d   = out_inj_q;
    if (s2_load) begin
      out_valid_d = 1'b1;
      out_code_d  = enc_code;
      out_inj_d   = |flip_mask;
    end else if (out_xfer) begin
      out_valid_d = 1'b0;
    end
  end

  // Counters advance on each hand-off and wrap naturally at 2^CNT_W.
  always_comb begin
    word_cnt_d = word_cnt_q;
    err_cnt_d  = err_cnt_q;
    if (out_xfer) begin
      word_cnt_d = word_cnt_q + CNT_W'(1);
      if (out_inj_q) err_cnt_d = err_cnt_q + CNT_W'(1);
    end
  end

  // State registers. Synchronous reset drops every in-flight word.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s1_inj_q    <= '0;
      out_valid_q <= 1'b0;
      out_code_q  <= '0;
      out_inj_q   <= 1'b0;
      word_cnt_q  <= '0;
      err_cnt_q   <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_data_q   <= s1_data_d;
      s1_inj_q    <= s1_inj_d;
      out_valid_q <= out_valid_d;
      out_code_q  <= out_code_d;
      out_inj_q   <= out_inj_d;
      word_cnt_q  <= word_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_code  = out_code_q;
  assign out_inj   = out_inj_q;
  assign word_cnt  = word_cnt_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_hamming_enc_stream.sv
// Scoreboard bench for hamming_enc_stream (IP_BIT=11, N=15).
// The driver pushes the expected result when a word is accepted. The monitor
// pops an entry on every output hand-off and checks it. Each codeword is also
// run through an independent syndrome decoder.
module tb_hamming_enc_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [10:0] in_data;
  logic [3:0]  inject_pos;
  logic        out_valid;
  logic        out_ready;
  logic [14:0] out_code;
  logic        out_inj;
  logic [15:0] word_cnt;
  logic [15:0] err_cnt;

  always #5 clk = ~clk;

  hamming_enc_stream #(.IP_BIT(11), .CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .inject_pos(inject_pos),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_code  (out_code),
    .out_inj   (out_inj),
    .word_cnt  (word_cnt),
    .err_cnt   (err_cnt)
  );

  typedef struct {
    logic [14:0] code;
    logic        chk_code;
    logic [10:0] data;
    logic        inj;
    logic [3:0]  syn;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   acc_cnt = 0;
  int   n_inj = 0;
  logic rnd_ready_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Receiver-side model: the syndrome locates a single flipped position, which
  // is corrected before the data bits are extracted.
  task automatic decode(input logic [14:0] c, output logic [3:0] syn, output logic [10:0] d);
    logic [14:0] cc;
    int          di;
    syn = 4'd0;
    for (int p = 1; p <= 15; p++) if (c[15-p]) syn = syn ^ 4'(p);
    cc = c;
    if (syn != 4'd0) cc[15-syn] = ~cc[15-syn];
    di = 10;
    d  = '0;
    for (int p = 1; p <= 15; p++) begin
      if ((p & (p - 1)) != 0) begin
        d[di] = cc[15-p];
        di--;
      end
    end
  endtask

  // Called on a negedge. Holds the word until accepted, then returns on the next negedge.
  task automatic send(input logic [10:0] d, input logic [3:0] ip,
                      input logic chk, input logic [14:0] code);
    exp_t e;
    int   guard;
    guard      = 0;
    in_valid   = 1'b1;
    in_data    = d;
    inject_pos = ip;
    #1;
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: in_ready stuck at 0 for data %0h", d);
    end else begin
      e.code     = code;
      e.chk_code = chk;
      e.data     = d;
      e.inj      = (ip >= 4'd1 && ip <= 4'd15);
      e.syn      = e.inj ? ip : 4'd0;
      sb.push_back(e);
      acc_cnt++;
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (sb.size() != 0 && g < 5000) begin
      @(negedge clk);
      g++;
    end
    if (sb.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: %0d words still expected", sb.size());
    end
    repeat (2) @(negedge clk);
  endtask

  // Monitor: samples just after the negedge, when inputs are settled for the coming posedge.
  initial begin
    exp_t        e;
    logic [3:0]  syn;
    logic [10:0] dd;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_word: got %0h, expected none", out_code);
        end else begin
          e = sb.pop_front();
          decode(out_code, syn, dd);
          if (e.chk_code) check("out_code", {17'd0, out_code}, {17'd0, e.code});
          check("out_inj", {31'd0, out_inj}, {31'd0, e.inj});
          check("syndrome", {28'd0, syn}, {28'd0, e.syn});
          check("decoded_data", {21'd0, dd}, {21'd0, e.data});
        end
      end
    end
  end

  // Random sink backpressure, enabled only during the random phase.
  initial begin
    forever begin
      @(negedge clk);
      if (rnd_ready_en) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [10:0] rd;
    logic [3:0]  rip;
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_data    = '0;
    inject_pos = '0;
    out_ready  = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_code",  {17'd0, out_code},  32'd0);
    check("rst_out_inj",   {31'd0, out_inj},   32'd0);
    check("rst_word_cnt",  {16'd0, word_cnt},  32'd0);
    check("rst_err_cnt",   {16'd0, err_cnt},   32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_reset", {31'd0, in_ready}, 32'd1);

    // Directed vectors
    send(11'h000, 4'd0,  1'b1, 15'h0000);
    drain();
    check("word_cnt_first", {16'd0, word_cnt}, 32'd1);
    check("err_cnt_first",  {16'd0, err_cnt},  32'd0);
    send(11'h001, 4'd0,  1'b1, 15'h6881);
    send(11'h400, 4'd0,  1'b1, 15'h7000);
    send(11'h7FF, 4'd0,  1'b1, 15'h7FFF);
    send(11'h001, 4'd3,  1'b1, 15'h7881);
    send(11'h001, 4'd0,  1'b1, 15'h6881);
    send(11'h001, 4'd15, 1'b1, 15'h6880);
    drain();
    check("word_cnt_directed", {16'd0, word_cnt}, 32'd7);
    check("err_cnt_directed",  {16'd0, err_cnt},  32'd2);

    // Backpressure: four back-to-back words while the sink stalls for 5 cycles
    out_ready = 1'b0;
    acc_cnt   = 0;
    fork
      begin
        send(11'h001, 4'd0, 1'b1, 15'h6881);
        send(11'h400, 4'd0, 1'b1, 15'h7000);
        send(11'h7FF, 4'd0, 1'b1, 15'h7FFF);
        send(11'h000, 4'd0, 1'b1, 15'h0000);
      end
      begin
        repeat (5) begin
          @(negedge clk);
          #1;
          if (out_valid) begin
            check("stall_hold_code", {17'd0, out_code}, 32'h6881);
            check("stall_hold_inj",  {31'd0, out_inj},  32'd0);
          end
        end
        check("stall_accepted", acc_cnt, 32'd2);
        check("stall_in_ready", {31'd0, in_ready}, 32'd0);
        check("stall_out_valid", {31'd0, out_valid}, 32'd1);
        @(negedge clk);
        out_ready = 1'b1;
      end
    join
    drain();
    check("word_cnt_bp", {16'd0, word_cnt}, 32'd11);

    // Random words with random injection and random backpressure, from a clean reset
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("word_cnt_cleared", {16'd0, word_cnt}, 32'd0);
    n_inj        = 0;
    rnd_ready_en = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      rd  = 11'($urandom_range(0, 2047));
      rip = 4'($urandom_range(0, 15));
      if (rip != 4'd0) n_inj++;
      send(rd, rip, 1'b0, 15'h0000);
    end
    drain();
    rnd_ready_en = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    check("word_cnt_random", {16'd0, word_cnt}, 32'd1000);
    check("err_cnt_random",  {16'd0, err_cnt},  n_inj);

    // Reset with two words in flight
    out_ready = 1'b0;
    send(11'h001, 4'd0, 1'b1, 15'h6881);
    send(11'h400, 4'd5, 1'b1, 15'h7400);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_word_cnt",  {16'd0, word_cnt},  32'd0);
    check("midrst_err_cnt",   {16'd0, err_cnt},   32'd0);
    sb.delete();
    rst       = 1'b0;
    out_ready = 1'b1;
    repeat (10) @(negedge clk);
    check("midrst_no_stale_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_no_stale_cnt",   {16'd0, word_cnt},  32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
